// File: rtl/vga_frame_out.sv
// vga_frame_out
// ---------------------------------------------------------------------------
// Display stage that sits after the Hough transform core. A whole
// post-processed frame is taken from FrameIn through a four-phase req/ack
// handshake and held in an internal frame register. The frame register is
// scanned continuously onto a VGA raster. Each image pixel is replicated
// SCALE x SCALE times, and the output is black outside the image window.
// A new frame is taken only on the last clock of a raster frame, so a
// displayed frame never mixes two images.
//
// Ports
//   Clk         in   pixel clock, one pixel per cycle
//   Reset       in   synchronous, active-high; clears the counters, the FSM
//                    and the frame register
//   FrameIn     in   flattened frame; pixel (r,c) is at
//                    [(r*MATRIX_N+c)*IMAGE_BITS +: IMAGE_BITS]
//   vgaReqOut   in   upstream frame-valid request (FrameIn stable while high)
//   vgaAckOut   out  frame-captured acknowledge
//   HSync       out  horizontal sync, active-low, registered
//   VSync       out  vertical sync, active-low, registered
//   Active      out  high inside the visible area, registered
//   Pixel       out  greyscale intensity, registered
//   FrameValid  out  high once at least one frame has been captured
// ---------------------------------------------------------------------------
module vga_frame_out #(
    parameter int IMAGE_BITS = 8,
    parameter int MATRIX_N   = 80,
    parameter int MATRIX_M   = 80,
    parameter int SCALE      = 4,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    localparam int FLAT_WIDE = IMAGE_BITS * MATRIX_N * MATRIX_M
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [FLAT_WIDE-1:0]  FrameIn,
    input  logic                  vgaReqOut,
    output logic                  vgaAckOut,
    output logic                  HSync,
    output logic                  VSync,
    output logic                  Active,
    output logic [IMAGE_BITS-1:0] Pixel,
    output logic                  FrameValid
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PIX_COUNT = MATRIX_N * MATRIX_M;

    localparam int H_W    = $clog2(H_TOTAL + 1);
    localparam int V_W    = $clog2(V_TOTAL + 1);
    localparam int SUB_W  = (SCALE > 1) ? $clog2(SCALE) : 1;
    // Column/row indices run one past the last image pixel when the window
    // closes, so they need room for MATRIX_N / MATRIX_M themselves.
    localparam int COL_W  = $clog2(MATRIX_N + 1);
    localparam int ROW_W  = $clog2(MATRIX_M + 1);
    localparam int ADDR_W = (PIX_COUNT > 1) ? $clog2(PIX_COUNT) : 1;

    localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT_END  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [H_W-1:0] H_IMG_END  = H_W'(MATRIX_N * SCALE);

    localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT_END  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_W-1:0] V_IMG_END  = V_W'(MATRIX_M * SCALE);

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);

    // ------------------------------------------------------------------
    // Raster counters plus replication sub-counters
    // ------------------------------------------------------------------
    logic [H_W-1:0]   hcnt_reg;
    logic [V_W-1:0]   vcnt_reg;
    logic [SUB_W-1:0] h_sub_reg;
    logic [SUB_W-1:0] v_sub_reg;
    logic [COL_W-1:0] h_idx_reg;   // hcnt / SCALE while inside the window
    logic [ROW_W-1:0] v_idx_reg;   // vcnt / SCALE while inside the window

    logic h_end;
    logic v_end;
    logic wrap;
    logic in_h;
    logic in_v;

    assign h_end = (hcnt_reg == H_LAST);
    assign v_end = (vcnt_reg == V_LAST);
    assign wrap  = h_end && v_end;
    assign in_h  = (hcnt_reg < H_IMG_END);
    assign in_v  = (vcnt_reg < V_IMG_END);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hcnt_reg  <= '0;
            vcnt_reg  <= '0;
            h_sub_reg <= '0;
            v_sub_reg <= '0;
            h_idx_reg <= '0;
            v_idx_reg <= '0;
        end else if (h_end) begin
            hcnt_reg  <= '0;
            h_sub_reg <= '0;
            h_idx_reg <= '0;
            if (v_end) begin
                vcnt_reg  <= '0;
                v_sub_reg <= '0;
                v_idx_reg <= '0;
            end else begin
                vcnt_reg <= vcnt_reg + 1'b1;
                // The row sub-counter advances at the end of every image
                // line so it already describes the next line at hcnt = 0.
                if (in_v) begin
                    if (v_sub_reg == SUB_LAST) begin
                        v_sub_reg <= '0;
                        v_idx_reg <= v_idx_reg + 1'b1;
                    end else begin
                        v_sub_reg <= v_sub_reg + 1'b1;
                    end
                end
            end
        end else begin
            hcnt_reg <= hcnt_reg + 1'b1;
            if (in_h) begin
                if (h_sub_reg == SUB_LAST) begin
                    h_sub_reg <= '0;
                    h_idx_reg <= h_idx_reg + 1'b1;
                end else begin
                    h_sub_reg <= h_sub_reg + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame register and its per-pixel view
    // ------------------------------------------------------------------
    logic [FLAT_WIDE-1:0]  frame_reg;
    logic [IMAGE_BITS-1:0] pix_mem [PIX_COUNT];
    logic [ADDR_W-1:0]     pix_addr;

    genvar gi;
    generate
        for (gi = 0; gi < PIX_COUNT; gi++) begin : g_pix
            assign pix_mem[gi] = frame_reg[gi*IMAGE_BITS +: IMAGE_BITS];
        end
    endgenerate

    // Only meaningful inside the image window; outside it the indices may
    // point past the frame, and the output mux forces black there.
    assign pix_addr = ADDR_W'(int'(v_idx_reg) * MATRIX_N + int'(h_idx_reg));

    // ------------------------------------------------------------------
    // Four-phase capture handshake
    // ------------------------------------------------------------------
    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   capture;

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                // Requests are taken only on the last raster clock, so the
                // new frame starts displaying at pixel (0,0).
                if (wrap && vgaReqOut) begin
                    capture    = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!vgaReqOut) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign vgaAckOut = (state_reg == ACK);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_reg  <= '0;
            FrameValid <= 1'b0;
        end else if (capture) begin
            frame_reg  <= FrameIn;
            FrameValid <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registered video outputs (one clock behind the counters)
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            HSync  <= 1'b1;
            VSync  <= 1'b1;
            Active <= 1'b0;
            Pixel  <= '0;
        end else begin
            HSync  <= ~((hcnt_reg >= H_SYNC_BEG) && (hcnt_reg < H_SYNC_END));
            VSync  <= ~((vcnt_reg >= V_SYNC_BEG) && (vcnt_reg < V_SYNC_END));
            Active <= (hcnt_reg < H_ACT_END) && (vcnt_reg < V_ACT_END);
            Pixel  <= (in_h && in_v) ? pix_mem[pix_addr] : '0;
        end
    end

endmodule

// File: tb/tb_vga_frame_out.sv
// tb_vga_frame_out
// ---------------------------------------------------------------------------
// Testbench for vga_frame_out on a shrunken raster (23 x 17 clocks, 4x3
// image replicated 3x). A behavioural model tracks the raster as a single
// linear position and the frame as a 2-D array; every clock the registered
// outputs are compared against it. Directed scenarios pin the model with
// hand-computed numbers, then a randomized phase mixes requests, early drops
// and resets.
// ---------------------------------------------------------------------------
module tb_vga_frame_out;

    localparam int IMAGE_BITS = 8;
    localparam int MATRIX_N   = 4;
    localparam int MATRIX_M   = 3;
    localparam int SCALE      = 3;
    localparam int H_ACTIVE   = 16;
    localparam int H_FP       = 2;
    localparam int H_SYNC     = 3;
    localparam int H_BP       = 2;
    localparam int V_ACTIVE   = 12;
    localparam int V_FP       = 1;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 2;
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 23
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 17
    localparam int FRAME      = H_TOTAL * V_TOTAL;                 // 391
    localparam int FLAT_WIDE  = IMAGE_BITS * MATRIX_N * MATRIX_M;

    logic                  Clk = 1'b0;
    logic                  Reset = 1'b1;
    logic [FLAT_WIDE-1:0]  FrameIn = '0;
    logic                  vgaReqOut = 1'b0;
    logic                  vgaAckOut;
    logic                  HSync;
    logic                  VSync;
    logic                  Active;
    logic [IMAGE_BITS-1:0] Pixel;
    logic                  FrameValid;

    int checks = 0;
    int errors = 0;

    vga_frame_out #(
        .IMAGE_BITS(IMAGE_BITS), .MATRIX_N(MATRIX_N), .MATRIX_M(MATRIX_M),
        .SCALE(SCALE),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .FrameIn(FrameIn),
        .vgaReqOut(vgaReqOut),
        .vgaAckOut(vgaAckOut),
        .HSync(HSync),
        .VSync(VSync),
        .Active(Active),
        .Pixel(Pixel),
        .FrameValid(FrameValid)
    );

    always #5 Clk = ~Clk;

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int m_buf [MATRIX_M][MATRIX_N];
    int m_pos = 0;          // raster position the DUT counters hold now
    bit m_ack = 1'b0;
    bit m_fv = 1'b0;
    bit m_hs = 1'b1;
    bit m_vs = 1'b1;
    bit m_act = 1'b0;
    int m_pix = 0;
    int out_x = -1;         // raster position the outputs currently show
    int out_y = -1;
    bit m_started = 1'b0;

    always @(posedge Clk) begin : model
        int x;
        int y;
        m_started <= 1'b1;
        if (Reset) begin
            m_pos <= 0;
            m_ack <= 1'b0;
            m_fv  <= 1'b0;
            m_hs  <= 1'b1;
            m_vs  <= 1'b1;
            m_act <= 1'b0;
            m_pix <= 0;
            out_x <= -1;
            out_y <= -1;
            for (int r = 0; r < MATRIX_M; r++)
                for (int c = 0; c < MATRIX_N; c++)
                    m_buf[r][c] <= 0;
        end else begin
            x = m_pos % H_TOTAL;
            y = m_pos / H_TOTAL;
            out_x <= x;
            out_y <= y;
            m_hs  <= !(x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC);
            m_vs  <= !(y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC);
            m_act <= (x < H_ACTIVE) && (y < V_ACTIVE);
            if (x < MATRIX_N * SCALE && y < MATRIX_M * SCALE)
                m_pix <= m_buf[y / SCALE][x / SCALE];
            else
                m_pix <= 0;
            if (!m_ack && m_pos == FRAME - 1 && vgaReqOut) begin
                for (int r = 0; r < MATRIX_M; r++)
                    for (int c = 0; c < MATRIX_N; c++)
                        m_buf[r][c] <= int'(FrameIn[(r*MATRIX_N+c)*IMAGE_BITS +: IMAGE_BITS]);
                m_fv  <= 1'b1;
                m_ack <= 1'b1;
            end else if (m_ack && !vgaReqOut) begin
                m_ack <= 1'b0;
            end
            m_pos <= (m_pos + 1) % FRAME;
        end
    end

    // Per-cycle comparison, away from the active edge
    always @(negedge Clk) begin
        if (m_started) begin
            check_int("HSync", int'(HSync), int'(m_hs));
            check_int("VSync", int'(VSync), int'(m_vs));
            check_int("Active", int'(Active), int'(m_act));
            check_int("Pixel", int'(Pixel), m_pix);
            check_int("vgaAckOut", int'(vgaAckOut), int'(m_ack));
            check_int("FrameValid", int'(FrameValid), int'(m_fv));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_pattern(input int kind);
        int v;
        for (int r = 0; r < MATRIX_M; r++) begin
            for (int c = 0; c < MATRIX_N; c++) begin
                case (kind)
                    0:       v = (r + c) % 256;
                    1:       v = 255;
                    default: v = int'($urandom_range(0, 255));
                endcase
                FrameIn[(r*MATRIX_N+c)*IMAGE_BITS +: IMAGE_BITS] = IMAGE_BITS'(v);
            end
        end
    endtask

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        while (m_pos != p && n < 2 * FRAME) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (m_pos != p) begin
            errors++;
            $display("FAIL wait_pos: position %0d never reached (at %0d)", p, m_pos);
        end
    endtask

    task automatic sample_at(input int x, input int y, output int val);
        int n;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!(out_x == x && out_y == y) && n < 2 * FRAME);
        val = int'(Pixel);
    endtask

    task automatic cycles_to_ack(input logic lvl, output int n);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (vgaAckOut !== lvl && n < 3 * FRAME);
    endtask

    int frame_a [FRAME];
    int frame_b [FRAME];

    task automatic record_frame(input bit second);
        int n;
        n = 0;
        while (!(out_x == 0 && out_y == 0) && n < 2 * FRAME) begin
            @(negedge Clk);
            n++;
        end
        for (int i = 0; i < FRAME; i++) begin
            if (second) frame_b[i] = int'(Pixel);
            else        frame_a[i] = int'(Pixel);
            @(negedge Clk);
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        int len;
        int v;
        int diffs;
        int pix00;

        // Reset held for three clocks
        repeat (3) @(negedge Clk);
        Reset = 1'b0;

        // HSync: first low 19 clocks after release, 3 clocks wide, period 23
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (HSync !== 1'b0 && n < 200);
        check_int("hsync_first_low", n, H_ACTIVE + H_FP + 1);
        check_int("hsync_first_low_lit", n, 19);
        len = 0;
        while (HSync === 1'b0 && len < 200) begin
            len++;
            @(negedge Clk);
        end
        check_int("hsync_width", len, 3);
        while (HSync !== 1'b0 && len < 200) begin
            @(negedge Clk);
            len++;
        end
        check_int("hsync_period", len, 23);

        // VSync: 2 lines low (46 clocks), period 391
        n = 0;
        while (VSync !== 1'b0 && n < 2 * FRAME) begin
            @(negedge Clk);
            n++;
        end
        len = 0;
        while (VSync === 1'b0 && len < 2 * FRAME) begin
            len++;
            @(negedge Clk);
        end
        check_int("vsync_width", len, 46);
        while (VSync !== 1'b0 && len < 2 * FRAME) begin
            @(negedge Clk);
            len++;
        end
        check_int("vsync_period", len, 391);

        // Active count over one frame: 16 * 12
        n = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (Active === 1'b1) n++;
            @(negedge Clk);
        end
        check_int("active_per_frame", n, 192);

        // Capture: pattern (r+c), request raised at hcnt=5, vcnt=2
        set_pattern(0);
        wait_pos(2 * H_TOTAL + 5);
        vgaReqOut = 1'b1;
        cycles_to_ack(1'b1, n);
        check_int("ack_latency", n, 340);
        check_int("frame_valid_after_capture", int'(FrameValid), 1);
        sample_at(12, 0, v);  check_int("pix_x12_y0", v, 0);
        sample_at(3, 3, v);   check_int("pix_x3_y3", v, 2);
        sample_at(5, 7, v);   check_int("pix_x5_y7", v, 3);
        sample_at(11, 8, v);  check_int("pix_x11_y8", v, 5);
        sample_at(0, 9, v);   check_int("pix_x0_y9", v, 0);

        // Four-phase hold: request stays high, FrameIn changes, no recapture
        set_pattern(1);
        repeat (2 * FRAME) @(negedge Clk);
        check_int("ack_held", int'(vgaAckOut), 1);
        sample_at(5, 7, v);   check_int("pix_hold_x5_y7", v, 3);
        vgaReqOut = 1'b0;
        cycles_to_ack(1'b0, n);
        check_int("ack_fall_latency", n, 1);

        // No request: identical stream on consecutive frames
        record_frame(1'b0);
        record_frame(1'b1);
        diffs = 0;
        for (int i = 0; i < FRAME; i++)
            if (frame_a[i] != frame_b[i]) diffs++;
        check_int("redisplay_diffs", diffs, 0);
        check_int("redisplay_x11_y8", frame_b[8 * H_TOTAL + 11], 5);
        check_int("frame_valid_kept", int'(FrameValid), 1);

        // Reset in the middle of an ACK
        set_pattern(2);
        pix00 = int'(FrameIn[IMAGE_BITS-1:0]);
        @(negedge Clk);
        len = FRAME - m_pos;
        vgaReqOut = 1'b1;
        cycles_to_ack(1'b1, n);
        check_int("ack_latency_random_pos", n, len);
        repeat (5) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check_int("rst_ack", int'(vgaAckOut), 0);
        check_int("rst_frame_valid", int'(FrameValid), 0);
        check_int("rst_pixel", int'(Pixel), 0);
        check_int("rst_hsync", int'(HSync), 1);
        Reset = 1'b0;
        cycles_to_ack(1'b1, n);
        check_int("ack_after_reset", n, 391);
        sample_at(1, 1, v);
        check_int("recaptured_pix00", v, pix00);
        vgaReqOut = 1'b0;
        repeat (3) @(negedge Clk);

        // Randomized mix of requests, early drops and resets
        for (int it = 0; it < 25; it++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 6) begin
                set_pattern(2);
                repeat ($urandom_range(0, FRAME)) @(negedge Clk);
                vgaReqOut = 1'b1;
                repeat ($urandom_range(1, 2 * FRAME)) @(negedge Clk);
                vgaReqOut = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge Clk);
            end else if (op < 9) begin
                repeat ($urandom_range(1, FRAME)) @(negedge Clk);
            end else begin
                Reset = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge Clk);
                Reset = 1'b0;
                repeat ($urandom_range(1, 50)) @(negedge Clk);
            end
        end
        repeat (FRAME) @(negedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_frame_out.md
# vga_frame_out

Downstream display stage for the Hough transform pipeline. It consumes the flattened post-processed frame that the `HT` core presents on `Output`, using the `vgaReqOut`/`vgaAckOut` handshake, and holds it in an internal frame register. It then scans the frame continuously onto a VGA raster, with integer pixel replication and black outside the image window. New frames are accepted only at frame boundaries, so the display never tears.

## Interface
Parameters:
- IMAGE_BITS, 8, bits per pixel
- MATRIX_N, 80, image columns
- MATRIX_M, 80, image rows
- SCALE, 4, replication factor per axis; requires MATRIX_N*SCALE <= H_ACTIVE and MATRIX_M*SCALE <= V_ACTIVE
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48, horizontal timing in clocks
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33, vertical timing in lines
- FLAT_WIDE (derived), IMAGE_BITS*MATRIX_N*MATRIX_M

Ports:
- Clk  in  1  clock, one pixel per cycle
- Reset  in  1  synchronous, active-high
- FrameIn  in  FLAT_WIDE  flattened frame; pixel (row r, col c) is at bits [(r*MATRIX_N+c)*IMAGE_BITS +: IMAGE_BITS]
- vgaReqOut  in  1  upstream frame-valid request; FrameIn must be stable while it is high
- vgaAckOut  out  1  frame-captured acknowledge
- HSync  out  1  horizontal sync, active-low
- VSync  out  1  vertical sync, active-low
- Active  out  1  high inside the H_ACTIVE x V_ACTIVE region
- Pixel  out  IMAGE_BITS  greyscale intensity
- FrameValid  out  1  high once at least one frame has been captured

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters:
  - hcnt runs 0..H_TOTAL-1 and wraps to 0.
  - vcnt increments when hcnt wraps and itself wraps at V_TOTAL-1.
- Sync:
  - HSync is low for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - VSync is low for the analogous vcnt range.
- Active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- Pixel:
  - Inside the image window (hcnt < MATRIX_N*SCALE, vcnt < MATRIX_M*SCALE), Pixel = buffer pixel (vcnt/SCALE, hcnt/SCALE).
  - Everywhere else, including blanking, Pixel = 0.
  - Division is integer. Sub-counters are the intended implementation; there are no dividers.
- Handshake FSM, four-phase, states IDLE / ACK:
  - IDLE: on the wrap cycle (hcnt = H_TOTAL-1, vcnt = V_TOTAL-1) with vgaReqOut = 1, capture FrameIn into the buffer, set FrameValid, and go to ACK.
  - ACK: vgaAckOut = 1. Stay in ACK while vgaReqOut = 1. When vgaReqOut = 0, go to IDLE.
  - No capture takes place while in ACK.
  - A request outside the wrap cycle waits for the next wrap.
  - With no request, the buffer is redisplayed unchanged.
- A request that drops before the wrap cycle is ignored; no ack is issued.
- Reset values:
  - hcnt = 0, vcnt = 0, buffer all 0.
  - State IDLE, vgaAckOut = 0, FrameValid = 0.
  - HSync = 1, VSync = 1, Active = 0, Pixel = 0.
- Reset mid-handshake or mid-frame:
  - Everything returns to the reset values on the next edge and the buffer is cleared.
  - Upstream sees vgaAckOut fall while vgaReqOut may still be high. That request is then serviced at the next wrap.

## Timing
- HSync, VSync, Active and Pixel are registered. Each reflects the hcnt/vcnt value of the previous cycle, giving a fixed 1-cycle latency.
- The first registered output after Reset deasserts corresponds to hcnt = 0, vcnt = 0, with Pixel = buffer(0,0) = 0.
- Capture happens on the edge ending the wrap cycle. On the following cycle:
  - vgaAckOut = 1.
  - The new buffer is in use; the first displayed pixel (0,0) of the new frame comes from it.
- vgaAckOut falls on the edge after the first cycle in which vgaReqOut = 0 is sampled in ACK.
- Frame period is H_TOTAL*V_TOTAL clocks (420000 with defaults).
- The Pixel value at a given raster position depends only on the buffer contents, never on FrameIn directly.

## Test plan
- Reset: hold Reset = 1 for 3 cycles, then release. Required: all outputs at their reset values throughout Reset. HSync first goes low for 96 cycles, starting 657 cycles after release. The HSync period measures 800.
- VSync: run one frame. Required: VSync is low for exactly 1600 consecutive clocks and repeats every 420000 clocks. Active is high for exactly 640*480 cycles per frame.
- Capture: FrameIn pixel(r,c) = (r+c)%256. Raise vgaReqOut at hcnt = 100, vcnt = 10. Required:
  - vgaAckOut stays 0 until the wrap, then rises exactly 1 cycle after it.
  - In the next frame, raster (x, y) = (4c+k, 4r+m) shows r+c for k, m in 0..3.
  - x >= 320 or y >= 320 shows 0.
- Four-phase hold: keep vgaReqOut = 1 for 2 more frames with FrameIn changed to all 0xFF. Required: no recapture and the display is unchanged. Drop vgaReqOut: vgaAckOut falls 1 cycle later.
- No request: after one capture, leave vgaReqOut = 0 for 2 frames. Required: the identical pixel stream is produced each frame and FrameValid stays 1.
- Reset mid-ACK: assert Reset while vgaAckOut = 1 and vgaReqOut = 1. Required: vgaAckOut = 0, FrameValid = 0 and Pixel = 0 after the edge. Recapture and ack occur at the next wrap.
